pulse_gen: RTL and testbench

Parametrised rectangular-pulse channel for the APU sound path, and the successor to the single-strobe square channel. It adds synchronous reset, per-register write strobes, and a channel-enable input. It implements the exact envelope start/loop, sweep reload and sweep-negate semantics, selectable per instance as ones' or twos' complement. Two instances (NEGATE_ONES=1 and 0) drive the mixer's pulse inputs.

---
 rtl/apu_pkg.sv | 58 +++++
 rtl/pulse_gen_if.sv | 14 +
 rtl/apu_envelope.sv | 54 +++++
 rtl/pulse_gen.sv | 156 +++++++++++++++
 tb/tb_pulse_gen.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Package : apu_pkg
// Shared APU length/duty tables and register field bit positions.
// Rev     : 1.0  initial release
// ============================================================================
package apu_pkg;

  localparam int R0_VOL_LSB    = 0;
  localparam int R0_CONST_BIT  = 4;
  localparam int R0_HALT_BIT   = 5;
  localparam int R0_DUTY_LSB   = 6;
  localparam int R1_SHIFT_LSB  = 0;
  localparam int R1_NEGATE_BIT = 3;
  localparam int R1_SPER_LSB   = 4;
  localparam int R1_SEN_BIT    = 7;
  localparam int R3_LEN_LSB    = 3;

  function automatic logic [7:0] length_table(input logic [4:0] idx);
    logic [7:0] len;
    len = 8'd0;
    case (idx)
      5'd0:  len = 8'd10;   5'd1:  len = 8'd254;
      5'd2:  len = 8'd20;   5'd3:  len = 8'd2;
      5'd4:  len = 8'd40;   5'd5:  len = 8'd4;
      5'd6:  len = 8'd80;   5'd7:  len = 8'd6;
      5'd8:  len = 8'd160;  5'd9:  len = 8'd8;
      5'd10: len = 8'd60;   5'd11: len = 8'd10;
      5'd12: len = 8'd14;   5'd13: len = 8'd12;
      5'd14: len = 8'd26;   5'd15: len = 8'd14;
      5'd16: len = 8'd12;   5'd17: len = 8'd16;
      5'd18: len = 8'd24;   5'd19: len = 8'd18;
      5'd20: len = 8'd48;   5'd21: len = 8'd20;
      5'd22: len = 8'd96;   5'd23: len = 8'd22;
      5'd24: len = 8'd192;  5'd25: len = 8'd24;
      5'd26: len = 8'd72;   5'd27: len = 8'd26;
      5'd28: len = 8'd16;   5'd29: len = 8'd28;
      5'd30: len = 8'd32;   5'd31: len = 8'd30;
      default: len = 8'd0;
    endcase
    return len;
  endfunction

  // Bit n of the pattern is the output level at sequencer index n.
  function automatic logic [7:0] duty_table(input logic [1:0] duty);
    logic [7:0] pat;
    pat = 8'h00;
    case (duty)
      2'd0:    pat = 8'b1000_0000;
      2'd1:    pat = 8'b1100_0000;
      2'd2:    pat = 8'b1111_0000;
      default: pat = 8'b0011_1111;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : pulse_gen_if
// CPU-side register write port of an APU pulse channel.
// Rev       : 1.0  initial release
// ============================================================================
interface pulse_gen_if;
  logic [7:0] reg_data;
  logic [3:0] reg_write;

  modport master (output reg_data, output reg_write);
  modport slave  (input  reg_data, input  reg_write);
endinterface
`default_nettype wire

// File: rtl/apu_envelope.sv
`default_nettype none
// ============================================================================
// Module : apu_envelope
// Envelope divider/decay unit shared by the pulse and noise channels.
// Rev    : 1.0  initial release
// ============================================================================
module apu_envelope (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       tick_i,
  input  wire logic       start_i,
  input  wire logic [3:0] volume_i,
  input  wire logic       loop_i,
  input  wire logic       const_i,
  output logic      [3:0] volume_o
);

  logic       start_q;
  logic [3:0] decay_q;
  logic [3:0] div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      decay_q <= 4'd0;
      div_q   <= 4'd0;
    end else begin
      if (tick_i) begin
        if (start_q) begin
          start_q <= 1'b0;
          decay_q <= 4'd15;
          div_q   <= volume_i;
        end else if (div_q == 4'd0) begin
          div_q <= volume_i;
          if (decay_q != 4'd0) begin
            decay_q <= decay_q - 4'd1;
          end else if (loop_i) begin
            decay_q <= 4'd15;
          end
        end else begin
          div_q <= div_q - 4'd1;
        end
      end
      // A write in the same cycle as a tick re-arms the flag for the next tick.
      if (start_i) begin
        start_q <= 1'b1;
      end
    end
  end

  assign volume_o = const_i ? volume_i : decay_q;

endmodule
`default_nettype wire

// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
// Module : pulse_gen
// APU rectangular-pulse channel: timer, duty sequencer, sweep, length, envelope.
// Rev    : 1.0  initial release
// ============================================================================
module pulse_gen
  import apu_pkg::*;
#(
  parameter int TIMER_WIDTH = 11,
  parameter bit NEGATE_ONES = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       enable_240hz,
  input  wire logic       enable_120hz,
  input  wire logic       channel_enable,
  pulse_gen_if.slave      bus,
  output logic      [3:0] pulse_data,
  output logic            length_active
);

  localparam int TW = TIMER_WIDTH;
  localparam logic [TW:0]   NEG_BIAS   = {{TW{1'b0}}, NEGATE_ONES};
  localparam logic [TW-1:0] MIN_PERIOD = TW'(8);

  logic [3:0]    vol_q;
  logic          cvol_q;
  logic          halt_q;
  logic [1:0]    duty_q;
  logic [2:0]    shift_q;
  logic          negate_q;
  logic [2:0]    sper_q;
  logic          sen_q;
  logic [TW-1:0] period_q;
  logic [7:0]    length_q;
  logic [2:0]    sdiv_q;
  logic          sreload_q;
  logic [TW:0]   timer_q;
  logic [2:0]    index_q;

  logic [TW-1:0] shifted;
  logic [TW:0]   period_x;
  logic [TW:0]   shifted_x;
  logic [TW:0]   subtrahend;
  logic [TW:0]   target;
  logic          mute;
  logic          step;
  logic [7:0]    pattern;
  logic [3:0]    env_volume;

  assign shifted    = period_q >> shift_q;
  assign period_x   = {1'b0, period_q};
  assign shifted_x  = {1'b0, shifted};
  assign subtrahend = shifted_x + NEG_BIAS;

  // The extra MSB of target flags overflow past the timer range.
  always_comb begin
    target = period_x + shifted_x;
    if (negate_q) begin
      target = (period_x < subtrahend) ? '0 : (period_x - subtrahend);
    end
  end

  assign mute    = (period_q < MIN_PERIOD) || target[TW];
  assign step    = (timer_q == '0);
  assign pattern = duty_table(duty_q);

  apu_envelope u_env (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (enable_240hz),
    .start_i  (bus.reg_write[3]),
    .volume_i (vol_q),
    .loop_i   (halt_q),
    .const_i  (cvol_q),
    .volume_o (env_volume)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q         <= 4'd0;
      cvol_q        <= 1'b0;
      halt_q        <= 1'b0;
      duty_q        <= 2'd0;
      shift_q       <= 3'd0;
      negate_q      <= 1'b0;
      sper_q        <= 3'd0;
      sen_q         <= 1'b0;
      period_q      <= '0;
      length_q      <= 8'd0;
      sdiv_q        <= 3'd0;
      sreload_q     <= 1'b0;
      timer_q       <= '0;
      index_q       <= 3'd0;
      pulse_data    <= 4'd0;
      length_active <= 1'b0;
    end else begin
      pulse_data    <= (pattern[index_q] && !mute && (length_q != 8'd0)) ? env_volume : 4'd0;
      length_active <= (length_q != 8'd0);

      // Reload samples period_q, so period changes land on the next reload.
      if (step) begin
        timer_q <= {period_q, 1'b1};
        index_q <= index_q - 3'd1;
      end else begin
        timer_q <= timer_q - 1'b1;
      end

      if (enable_120hz) begin
        if ((sdiv_q == 3'd0) && sen_q && (shift_q != 3'd0) && !mute) begin
          period_q <= target[TW-1:0];
        end
        if ((sdiv_q == 3'd0) || sreload_q) begin
          sdiv_q    <= sper_q;
          sreload_q <= 1'b0;
        end else begin
          sdiv_q <= sdiv_q - 3'd1;
        end
        if ((length_q != 8'd0) && !halt_q) begin
          length_q <= length_q - 8'd1;
        end
      end

      // Register writes come last so they win over same-cycle tick updates.
      if (bus.reg_write[0]) begin
        vol_q  <= bus.reg_data[R0_VOL_LSB +: 4];
        cvol_q <= bus.reg_data[R0_CONST_BIT];
        halt_q <= bus.reg_data[R0_HALT_BIT];
        duty_q <= bus.reg_data[R0_DUTY_LSB +: 2];
      end
      if (bus.reg_write[1]) begin
        shift_q   <= bus.reg_data[R1_SHIFT_LSB +: 3];
        negate_q  <= bus.reg_data[R1_NEGATE_BIT];
        sper_q    <= bus.reg_data[R1_SPER_LSB +: 3];
        sen_q     <= bus.reg_data[R1_SEN_BIT];
        sreload_q <= 1'b1;
      end
      if (bus.reg_write[2]) begin
        period_q[7:0] <= bus.reg_data;
      end
      if (bus.reg_write[3]) begin
        period_q[TW-1:8] <= bus.reg_data[TW-9:0];
        index_q          <= 3'd0;
        if (channel_enable) begin
          length_q <= length_table(bus.reg_data[R3_LEN_LSB +: 5]);
        end
      end
      if (!channel_enable) begin
        length_q <= 8'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_pulse_gen
// Self-checking bench for both negate flavours of pulse_gen.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic       e240 = 1'b0;
  logic       e120 = 1'b0;
  logic [3:0] pd0, pd1;
  logic       la0, la1;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_gen_if bus ();

  pulse_gen #(.TIMER_WIDTH(11), .NEGATE_ONES(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .enable_240hz(e240), .enable_120hz(e120),
    .channel_enable(ce), .bus(bus.slave), .pulse_data(pd0), .length_active(la0)
  );

  pulse_gen #(.TIMER_WIDTH(11), .NEGATE_ONES(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .enable_240hz(e240), .enable_120hz(e120),
    .channel_enable(ce), .bus(bus.slave), .pulse_data(pd1), .length_active(la1)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = twos' complement, index 1 = ones' complement.
  typedef struct {
    int vol, cvol, halt, duty, shift, neg, sper, sen, period;
    int length, decay, ediv, estart, sdiv, sreload, timer, index, pd, la;
  } mstate_t;
  mstate_t mdl[2];

  function automatic int len_tab(input int i);
    int t[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                  12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
    return t[i];
  endfunction

  function automatic int duty_bit(input int d, input int idx);
    int pats[4] = '{'h80, 'hC0, 'hF0, 'h3F};
    return (pats[d] >> idx) & 1;
  endfunction

  function automatic int sweep_target(input int p, input int sh, input int neg, input int ones);
    int s, t;
    s = p >> sh;
    if (neg != 0) begin
      t = p - s - ones;
      if (t < 0) t = 0;
    end else begin
      t = p + s;
    end
    return t;
  endfunction

  task automatic model_edge();
    int d, w;
    d = int'(bus.reg_data);
    w = int'(bus.reg_write);
    for (int m = 0; m < 2; m++) begin
      mstate_t o, s;
      int t;
      bit mu;
      o = mdl[m];
      s = o;
      if (rst) begin
        s = '{default: 0};
      end else begin
        t  = sweep_target(o.period, o.shift, o.neg, m);
        mu = (o.period < 8) || (t >= 2048);
        s.pd = (duty_bit(o.duty, o.index) != 0 && !mu && o.length != 0)
               ? ((o.cvol != 0) ? o.vol : o.decay) : 0;
        s.la = (o.length != 0) ? 1 : 0;
        if (e240) begin
          if (o.estart != 0) begin
            s.estart = 0; s.decay = 15; s.ediv = o.vol;
          end else if (o.ediv == 0) begin
            s.ediv = o.vol;
            if (o.decay != 0) s.decay = o.decay - 1;
            else if (o.halt != 0) s.decay = 15;
          end else begin
            s.ediv = o.ediv - 1;
          end
        end
        if (e120) begin
          if (o.sdiv == 0 && o.sen != 0 && o.shift != 0 && !mu) s.period = t;
          if (o.sdiv == 0 || o.sreload != 0) begin
            s.sdiv = o.sper; s.sreload = 0;
          end else begin
            s.sdiv = o.sdiv - 1;
          end
          if (o.length != 0 && o.halt == 0) s.length = o.length - 1;
        end
        if (o.timer == 0) begin
          s.timer = 2 * o.period + 1;
          s.index = (o.index + 7) % 8;
        end else begin
          s.timer = o.timer - 1;
        end
        if (w[0]) begin
          s.vol = d & 15; s.cvol = (d >> 4) & 1; s.halt = (d >> 5) & 1; s.duty = d >> 6;
        end
        if (w[1]) begin
          s.shift = d & 7; s.neg = (d >> 3) & 1; s.sper = (d >> 4) & 7; s.sen = d >> 7;
          s.sreload = 1;
        end
        if (w[2]) s.period = (s.period & 'h700) | d;
        if (w[3]) begin
          s.period = (s.period & 'hFF) | ((d & 7) << 8);
          s.estart = 1;
          s.index  = 0;
          if (ce) s.length = len_tab(d >> 3);
        end
        if (!ce) s.length = 0;
      end
      mdl[m] = s;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit a240, input bit a120,
                     input logic [3:0] w, input logic [7:0] d);
    rst = r; ce = c; e240 = a240; e120 = a120;
    bus.reg_write = w; bus.reg_data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0; e240 = 1'b0; e120 = 1'b0; bus.reg_write = 4'd0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pd0"}, 32'(pd0), 32'(mdl[0].pd));
    check({tag, "_la0"}, 32'(la0), 32'(mdl[0].la));
    check({tag, "_pd1"}, 32'(pd1), 32'(mdl[1].pd));
    check({tag, "_la1"}, 32'(la1), 32'(mdl[1].la));
  endtask

  typedef struct {
    bit         r;
    bit         c;
    logic [3:0] w;
    logic [7:0] d;
    bit         exp_la;
    logic [3:0] exp_pd;
  } vec_t;
  vec_t vt[9];

  initial begin
    int cnt0, cnt1;
    bus.reg_write = 4'd0;
    bus.reg_data  = 8'd0;

    // Reset, enable gating, length load (outputs lag state by one clk).
    vt[0] = '{1'b1, 1'b0, 4'b0000, 8'h00, 1'b0, 4'd0};
    vt[1] = '{1'b0, 1'b0, 4'b1000, 8'h08, 1'b0, 4'd0};
    vt[2] = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 4'd0};
    vt[3] = '{1'b0, 1'b1, 4'b0001, 8'h9F, 1'b0, 4'd0};
    vt[4] = '{1'b0, 1'b1, 4'b0100, 8'h08, 1'b0, 4'd0};
    vt[5] = '{1'b0, 1'b1, 4'b1000, 8'h08, 1'b0, 4'd0};
    vt[6] = '{1'b0, 1'b1, 4'b0000, 8'h00, 1'b1, 4'd0};
    vt[7] = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 4'd0};
    vt[8] = '{1'b0, 1'b1, 4'b0000, 8'h00, 1'b0, 4'd0};
    for (int i = 0; i < 9; i++) begin
      cyc(vt[i].r, vt[i].c, 1'b0, 1'b0, vt[i].w, vt[i].d);
      check($sformatf("vec%0d_la1", i), 32'(la1), 32'(vt[i].exp_la));
      check($sformatf("vec%0d_pd1", i), 32'(pd1), 32'(vt[i].exp_pd));
      check($sformatf("vec%0d_la0", i), 32'(la0), 32'(vt[i].exp_la));
      check($sformatf("vec%0d_pd0", i), 32'(pd0), 32'(vt[i].exp_pd));
    end

    // Length load with halt: 50% duty, step every 508 clk.
    cyc(1, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 0, 0, 4'b0001, 8'hBF);
    cyc(0, 1, 0, 0, 4'b0100, 8'hFD);
    cyc(0, 1, 0, 0, 4'b1000, 8'h08);
    for (int i = 0; i < 600; i++) cyc(0, 1, (i % 97) == 0, (i % 97) == 0, 4'd0, 8'd0);
    cnt1 = 0;
    for (int i = 0; i < 4064; i++) begin
      cyc(0, 1, (i % 97) == 0, (i % 97) == 0, 4'd0, 8'd0);
      if (pd1 == 4'd15) cnt1++;
    end
    check("duty2_high_clks", 32'(cnt1), 32'd2032);
    check("halt_length", 32'(u_dut1.length_q), 32'd254);
    check("halt_la", 32'(la1), 32'd1);

    // Length load coincident with a 120 Hz tick loads the full table value.
    cyc(1, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 0, 0, 4'b0001, 8'h9F);
    cyc(0, 1, 1, 1, 4'b1000, 8'h18);
    cyc(0, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 1, 1, 4'b0000, 8'h00);
    cyc(0, 1, 1, 1, 4'b0000, 8'h00);
    check("collide_la_last", 32'(la1), 32'd1);
    cyc(0, 1, 0, 0, 4'b0000, 8'h00);
    check("collide_la_zero", 32'(la1), 32'd0);

    // Envelope decay with loop, rate 2.
    cyc(1, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 0, 0, 4'b0001, 8'h22);
    cyc(0, 1, 0, 0, 4'b1000, 8'h08);
    for (int k = 1; k <= 49; k++) begin
      cyc(0, 1, 1, 0, 4'd0, 8'd0);
      cyc(0, 1, 0, 0, 4'd0, 8'd0);
      check($sformatf("decay_tick%0d", k), 32'(u_dut1.u_env.decay_q),
            (k <= 48) ? 32'(15 - (k - 1) / 3) : 32'd15);
    end

    // Sweep negate on period 0x100, shift 1, sweep period 0.
    cyc(1, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 0, 0, 4'b0100, 8'h00);
    cyc(0, 1, 0, 0, 4'b1000, 8'h01);
    cyc(0, 1, 0, 0, 4'b0010, 8'h89);
    cyc(0, 1, 1, 1, 4'b0000, 8'h00);
    check("sweep1_ones", 32'(u_dut1.period_q), 32'h7F);
    check("sweep1_twos", 32'(u_dut0.period_q), 32'h80);
    cyc(0, 1, 1, 1, 4'b0000, 8'h00);
    check("sweep2_ones", 32'(u_dut1.period_q), 32'h3F);
    check("sweep2_twos", 32'(u_dut0.period_q), 32'h40);

    // Mute by overflow target, then by short period.
    cyc(1, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 0, 0, 4'b0001, 8'hFF);
    cyc(0, 1, 0, 0, 4'b0010, 8'h80);
    cyc(0, 1, 0, 0, 4'b0100, 8'hFF);
    cyc(0, 1, 0, 0, 4'b1000, 8'h0F);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, (i % 10) == 0, (i % 10) == 0, 4'd0, 8'd0);
      if (pd0 != 4'd0) cnt0++;
      if (pd1 != 4'd0) cnt1++;
    end
    check("mute_ovf_pd0", 32'(cnt0), 32'd0);
    check("mute_ovf_pd1", 32'(cnt1), 32'd0);
    check("mute_ovf_la1", 32'(la1), 32'd1);
    cyc(0, 1, 0, 0, 4'b0010, 8'h81);
    cyc(0, 1, 0, 0, 4'b0100, 8'h07);
    cyc(0, 1, 0, 0, 4'b1000, 8'h08);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, (i % 10) == 0, (i % 10) == 0, 4'd0, 8'd0);
      if (pd0 != 4'd0) cnt0++;
      if (pd1 != 4'd0) cnt1++;
    end
    check("mute_p7_pd0", 32'(cnt0), 32'd0);
    check("mute_p7_pd1", 32'(cnt1), 32'd0);
    check("mute_p7_period1", 32'(u_dut1.period_q), 32'd7);
    check("mute_p7_period0", 32'(u_dut0.period_q), 32'd7);

    // Reset mid-tone, with a coincident reg3 strobe that must be ignored.
    cyc(0, 1, 0, 0, 4'b0010, 8'h00);
    cyc(0, 1, 0, 0, 4'b0100, 8'h10);
    cyc(0, 1, 0, 0, 4'b1000, 8'h08);
    cnt1 = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 0, 0, 4'd0, 8'd0);
      if (pd1 != 4'd0) cnt1++;
    end
    check("tone_present", 32'(cnt1 > 0), 32'd1);
    cyc(1, 1, 0, 0, 4'b1000, 8'h08);
    check("rst_pd1", 32'(pd1), 32'd0);
    check("rst_la1", 32'(la1), 32'd0);
    check("rst_pd0", 32'(pd0), 32'd0);
    cyc(0, 1, 0, 0, 4'b0000, 8'h00);
    cyc(0, 1, 0, 0, 4'b0000, 8'h00);
    check("rst_strobe_ignored", 32'(la1), 32'd0);

    // Randomised traffic against the reference model.
    cyc(1, 1, 0, 0, 4'b0000, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      bit         a240, a120, c;
      logic [3:0] w;
      a240 = ($urandom % 8) == 0;
      a120 = a240 && ($urandom % 2 == 1);
      c    = ($urandom % 16) != 0;
      w    = (($urandom % 6) == 0) ? 4'($urandom) : 4'd0;
      cyc(($urandom % 500) == 0, c, a240, a120, w, 8'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
